fma16_arbiter: RTL
==================

Name: fma16_arbiter

Overview:
- Sequencing controller that shares one half-precision fused multiply-add datapath (x*y+z, 16-bit operands/result) between two requesters.
- Accepts operand triples over per-requester valid/ready channels and arbitrates round-robin.
- Drives the shared datapath for a fixed latency, captures its result, and returns it on the owning requester's response channel.
- Sits between the FMA16 datapath and its clients; one operation in flight at a time.

Parameters:
LAT, 2, cycles from fma_start to valid fma_result; legal range 1..15 (1 = combinational datapath).
CNTW, 16, width of the completed-operation counter.

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 operands valid
req0_ready  out  1  requester 0 accept
req0_x  in  16  requester 0 multiplicand
req0_y  in  16  requester 0 multiplier
req0_z  in  16  requester 0 addend
req1_valid  in  1  requester 1 operands valid
req1_ready  out  1  requester 1 accept
req1_x  in  16  requester 1 multiplicand
req1_y  in  16  requester 1 multiplier
req1_z  in  16  requester 1 addend
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp1_valid  out  1  result for requester 1 available
rsp1_ready  in  1  requester 1 takes result
rsp_data  out  16  captured result, shared by both response channels
fma_start  out  1  one-cycle pulse, first cycle of execution
fma_x  out  16  operand x to datapath
fma_y  out  16  operand y to datapath
fma_z  out  16  operand z to datapath
fma_result  in  16  datapath result
done_count  out  CNTW  completed responses

Behaviour:

Reset:
- Reset is synchronous active-low: on a clk edge with reset_n=0, state=IDLE, the operand registers fma_x/y/z=0, rsp_data=0, done_count=0, last_grant=1 (so req0 wins the first tie), and the EXEC counter=0.
- Combinational outputs are 0 while in reset.

FSM states:
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid; if both are valid, the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N, combinational from valid; the other ready is 0.
  - Accept on reqN_valid && reqN_ready: load fma_x/y/z from reqN operands, owner=N, last_grant=N, cnt=LAT-1, go to EXEC.
  - A valid dropped before acceptance has no effect.
- EXEC:
  - Both readys are 0. fma_x/y/z are held stable.
  - fma_start=1 only in the first EXEC cycle.
  - If cnt!=0, decrement cnt. If cnt==0, rsp_data<=fma_result and go to RESP.
  - EXEC lasts exactly LAT cycles.
- RESP:
  - rsp<owner>_valid=1, the other rsp valid=0, both readys=0; rsp_data is held.
  - On rsp<owner>_ready: done_count+=1 (wraps all-ones to 0), go to IDLE.
  - The ready of the non-owner is ignored.

Timing:
- Accept at edge t. EXEC covers cycles t..t+LAT-1. rsp valid from cycle t+LAT.
- Earliest next accept is in the same cycle as the response handshake's successor IDLE cycle.
- Throughput is 1 op per LAT+2 cycles with zero backpressure.

Arbitration and ordering:
- Fairness: with both requesters continuously valid, grants strictly alternate. Neither requester waits more than one operation.
- Operands are captured at accept; later changes on reqN_x/y/z do not affect the in-flight op.
- fma_x/y/z keep their last value after RESP; the datapath output is ignored outside the capture cycle.

Boundary conditions:
- Reset mid-EXEC or mid-RESP: the operation is dropped, no response is issued, and done_count is cleared.
- LAT=1: fma_start and capture happen in the same single EXEC cycle.
- No combinational path from rspN_ready to reqN_ready: ready rises only in IDLE, the cycle after the response handshake.

Test Plan:
1. Single op, LAT=2, bench datapath model: req0 x=0x3C00, y=0x4000, z=0x3C00, held valid → req0_ready=1 in the accept cycle; fma_start one pulse; fma_x/y/z=0x3C00/0x4000/0x3C00; rsp0_valid rises 2 cycles after accept with rsp_data=0x4200; rsp1_valid=0; done_count=1 after rsp0_ready.
2. Tie after reset: req0 and req1 valid in the same cycle → req0 granted first; req1 granted on the next IDLE. With both held valid for 6 ops, grant order is 0,1,0,1,0,1 and done_count=6.
3. Backpressure: hold rsp1_ready=0 for 10 cycles → rsp1_valid and rsp_data stay stable; req0_ready and req1_ready stay 0; no fma_start pulses; on ready, state returns to IDLE next cycle.
4. Operand stability: change req0_x from 0x3C00 to 0x7BFF the cycle after accept → fma_x stays 0x3C00 for all EXEC cycles.
5. Reset mid-op: assert reset_n=0 in EXEC cycle 1 → no rsp valid ever appears for that op; all outputs are 0 on the next edge; done_count=0.
6. LAT=1 and counter wrap: build with CNTW=2 and run 4 ops → done_count reads 1,2,3,0; each rsp valid appears 1 cycle after accept.

Source files
------------

// File: rtl/fma16_arbiter.sv
// fma16_arbiter
// Shares one half-precision fused multiply-add datapath (x*y+z) between two
// requesters. Operand triples arrive on per-requester valid/ready channels and
// are granted round-robin. The selected triple drives the datapath for LAT
// cycles, the result is captured, and it is returned on the owner's response
// channel. Only one operation is in flight at a time.

module fma16_arbiter #(
    parameter int LAT  = 2,   // datapath latency in cycles, 1..15 (1 = combinational)
    parameter int CNTW = 16   // completed-operation counter width
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [15:0]     req0_x,
    input  logic [15:0]     req0_y,
    input  logic [15:0]     req0_z,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [15:0]     req1_x,
    input  logic [15:0]     req1_y,
    input  logic [15:0]     req1_z,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [15:0]     rsp_data,
    output logic            fma_start,
    output logic [15:0]     fma_x,
    output logic [15:0]     fma_y,
    output logic [15:0]     fma_z,
    input  logic [15:0]     fma_result,
    output logic [CNTW-1:0] done_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Counter value loaded at accept; EXEC ends when it reaches zero, so the
    // first EXEC cycle is recognisable as cnt == CNT_INIT.
    localparam logic [3:0]      CNT_INIT = 4'(LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [3:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       acc0;
    logic       acc1;
    logic       rsp_take;
    logic       capture;

    // Round-robin choice: a lone valid wins, a tie goes to whoever was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (!req0_valid && req1_valid)
            grant = 1'b1;
        else
            grant = ~last_grant;
    end

    // Handshake outputs are forced low while reset is asserted.
    assign req0_ready = reset_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = reset_n && (state == IDLE) && req1_valid &&  grant;
    assign fma_start  = reset_n && (state == EXEC) && (cnt == CNT_INIT);
    assign rsp0_valid = reset_n && (state == RESP) && !owner;
    assign rsp1_valid = reset_n && (state == RESP) &&  owner;

    assign acc0     = req0_valid && req0_ready;
    assign acc1     = req1_valid && req1_ready;
    assign rsp_take = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign capture  = (state == EXEC) && (cnt == 4'd0);

    // Sequencing FSM: accept in IDLE, count down the datapath latency, hold the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        owner      <= acc1;
                        last_grant <= acc1;
                        cnt        <= CNT_INIT;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        done_count <= done_count + CNT_ONE;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture at accept and result capture on the last EXEC cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fma_x    <= 16'd0;
            fma_y    <= 16'd0;
            fma_z    <= 16'd0;
            rsp_data <= 16'd0;
        end else begin
            if (acc0) begin
                fma_x <= req0_x;
                fma_y <= req0_y;
                fma_z <= req0_z;
            end else if (acc1) begin
                fma_x <= req1_x;
                fma_y <= req1_y;
                fma_z <= req1_z;
            end
            if (capture)
                rsp_data <= fma_result;
        end
    end

endmodule
